// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state codes and requester indices.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  // FSM states
  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t RESP  = 2'd3;

  // Requester indices into req/we/addr/wdata
  localparam int unsigned REQ_LD  = 0;  // program loader
  localparam int unsigned REQ_IF  = 1;  // instruction fetch
  localparam int unsigned REQ_DM  = 2;  // data access
  localparam int unsigned NUM_REQ = 3;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory arbiter.
//   req : request vector, bit 0 = loader, bit 1 = fetch, bit 2 = data
//   ptr : round-robin start index (ignored in the fixed-priority build)
//   win : one-hot winner, all zero when no request is present
// Build option: MEM_ARB_ROUND_ROBIN_EN selects the round-robin search starting at ptr;
// otherwise fixed priority loader > data > fetch.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    logic found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win = '0;
    if (req[REQ_LD])      win[REQ_LD] = 1'b1;
    else if (req[REQ_DM]) win[REQ_DM] = 1'b1;
    else if (req[REQ_IF]) win[REQ_IF] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the program loader, the core instruction
// fetch and the core data port. Each access runs IDLE -> ISSUE [-> WAIT] [-> RESP] -> IDLE.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   req, we                : per-requester request / write flag (bit i = requester i)
//   addr, wdata            : per-requester address / write data, slice i belongs to requester i
//   gnt, rvalid            : one-hot pulses for request accepted / read data valid
//   rdata                  : shared read data, held between responses
//   busy                   : FSM not in IDLE
//   mem_addr, mem_wdata,
//   mem_rden, mem_wren     : RAM side address, data and strobes
//   mem_q                  : RAM read data, valid RD_LAT clocks after the strobe edge
// Build option: MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_rden,
  output logic                       mem_wren,
  input  logic [DATA_W-1:0]          mem_q
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  win, win_q;
  logic                we_sel, we_q;
  logic [ADDR_W-1:0]   addr_sel, addr_q;
  logic [DATA_W-1:0]   wdata_sel, wdata_q, rdata_q;
  logic [1:0]          ptr;
  logic                take;

  // A request is only accepted from IDLE; anything raised while busy waits.
  assign take = (state_q == IDLE) && (|req);

  arb_pick u_arb_pick (
    .req (req),
    .ptr (ptr),
    .win (win)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  // Next search starts just after the requester that won.
  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      unique case (win)
        3'b001:  ptr_d = 2'd1;
        3'b010:  ptr_d = 2'd2;
        3'b100:  ptr_d = 2'd0;
        default: ptr_d = ptr_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  assign ptr = 2'd0;
`endif

  // Mux the winning requester's fields.
  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        we_sel    = we[i];
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take) state_d = ISSUE;
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (RD_LAT > 1) begin
          // WAIT spans RD_LAT-1 cycles: count RD_LAT-2 down to 0.
          state_d = WAIT;
          cnt_d   = CntW'(RD_LAT - 2);
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        win_q   <= win;
        we_q    <= we_sel;
        addr_q  <= addr_sel;
        wdata_q <= wdata_sel;
      end
      if (state_q == RESP) rdata_q <= mem_q;
    end
  end

  // addr_q/wdata_q only change on entry to ISSUE, so they hold their value elsewhere.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = (state_q == ISSUE) && we_q;
  assign mem_rden  = (state_q == ISSUE) && !we_q;
  assign gnt       = (state_q == ISSUE) ? win_q : '0;
  assign rvalid    = (state_q == RESP) ? win_q : '0;
  // In RESP the RAM output is passed straight through so rdata lines up with rvalid.
  assign rdata     = (state_q == RESP) ? mem_q : rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW     = 9;
  localparam int DW     = 16;
  localparam int RD_LAT = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      req   = '0;
  logic [2:0]      we    = '0;
  logic [3*AW-1:0] addr  = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, mem_wdata, mem_q;
  logic [AW-1:0]   mem_addr;
  logic            busy, mem_rden, mem_wren;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rden  (mem_rden),
    .mem_wren  (mem_wren),
    .mem_q     (mem_q)
  );

  // RAM model: strobe sampled at the edge, q valid RD_LAT edges later.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clock) begin
    if (mem_rden) pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_wren) ram[mem_addr] = mem_wdata;
  end
  assign mem_q = pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int cyc; int w; bit wr; logic [AW-1:0] a; logic [DW-1:0] d; } gexp_t;
  typedef struct { int cyc; int w; logic [DW-1:0] d; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int next_sample = 0;
  int busy_from   = 1;
  int busy_until  = 0;
  int rr_ptr      = 0;
  logic [DW-1:0] last_rd = '0;
  logic [2:0]    gnt_last = '0;

  function automatic int pick(input logic [2:0] r, input int p);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
    return -1;
`else
    if (r[0]) return 0;
    if (r[2]) return 2;
    if (r[1]) return 1;
    return -1;
`endif
  endfunction

  always @(negedge clock) begin
    int c;
    int w;
    gexp_t ge;
    rexp_t re;
    c = cyc;
    if (gq.size() > 0 && gq[0].cyc < c) begin
      ge = gq.pop_front();
      checks++; failures++;
      $display("FAIL gnt_missing: got none expected gnt for req %0d at cycle %0d", ge.w, ge.cyc);
    end
    if (rq.size() > 0 && rq[0].cyc < c) begin
      re = rq.pop_front();
      checks++; failures++;
      $display("FAIL rvalid_missing: got none expected rvalid for req %0d at cycle %0d",
               re.w, re.cyc);
    end
    chk("strobe_excl", 64'(mem_rden && mem_wren), 64'(0));
    if (gq.size() > 0 && gq[0].cyc == c) begin
      ge = gq.pop_front();
      chk("gnt", 64'(gnt), 64'(3'b001 << ge.w));
      chk("mem_addr", 64'(mem_addr), 64'(ge.a));
      chk("mem_wdata", 64'(mem_wdata), 64'(ge.d));
      chk("mem_wren", 64'(mem_wren), 64'(ge.wr));
      chk("mem_rden", 64'(mem_rden), 64'(!ge.wr));
    end else begin
      chk("gnt_quiet", 64'(gnt), 64'(0));
      chk("strobe_quiet", 64'({mem_wren, mem_rden}), 64'(0));
    end
    if (rq.size() > 0 && rq[0].cyc == c) begin
      re = rq.pop_front();
      chk("rvalid", 64'(rvalid), 64'(3'b001 << re.w));
      chk("rdata", 64'(rdata), 64'(re.d));
      last_rd = re.d;
    end else begin
      chk("rvalid_quiet", 64'(rvalid), 64'(0));
      chk("rdata_hold", 64'(rdata), 64'(last_rd));
    end
    chk("busy", 64'(busy), 64'(c >= busy_from && c <= busy_until));
    gnt_last = gnt;

    // Model update from the inputs the DUT samples at the coming edge.
    if (reset) begin
      gq.delete();
      rq.delete();
      next_sample = c + 1;
      busy_until  = c;
      last_rd     = '0;
      rr_ptr      = 0;
    end else if (c >= next_sample && req != 0) begin
      w = pick(req, rr_ptr);
      rr_ptr = (w + 1) % 3;
      ge.cyc = c + 1;
      ge.w   = w;
      ge.wr  = we[w];
      ge.a   = addr[w*AW +: AW];
      ge.d   = wdata[w*DW +: DW];
      gq.push_back(ge);
      if (ge.wr) begin
        shadow[ge.a] = ge.d;
        next_sample  = c + 2;
      end else begin
        re.cyc = c + 1 + RD_LAT;
        re.w   = w;
        re.d   = shadow[ge.a];
        rq.push_back(re);
        next_sample = c + 2 + RD_LAT;
      end
      busy_from  = c + 1;
      busy_until = next_sample - 1;
    end
  end

  // ---------------- stimulus ----------------
  logic [2:0]    act = '0;
  logic          t_we [3];
  logic [AW-1:0] t_addr [3];
  logic [DW-1:0] t_wd [3];

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      req[i]               = act[i];
      we[i]                = t_we[i];
      addr[i*AW +: AW]     = t_addr[i];
      wdata[i*DW +: DW]    = t_wd[i];
    end
  endtask

  task automatic set_txn(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    act[i] = 1'b1; t_we[i] = w; t_addr[i] = a; t_wd[i] = d;
    apply();
  endtask

  task automatic drive_cycle(input bit allow_new, input bit sticky);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      if (act[i] && gnt_last[i] && !sticky) act[i] = 1'b0;
      if (allow_new && !act[i] && $urandom_range(0, 3) == 0) begin
        act[i]    = 1'b1;
        t_we[i]   = 1'($urandom_range(0, 1));
        t_addr[i] = ($urandom_range(0, 9) == 0) ? 9'h1FF : AW'($urandom_range(0, 7));
        t_wd[i]   = DW'($urandom);
      end
    end
    apply();
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (act != 0 && n < bound) begin
      drive_cycle(0, 0);
      n++;
    end
    chk(name, 64'(act), 64'(0));
    act = '0;
    apply();
    repeat (RD_LAT + 3) drive_cycle(0, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'(i * 37 + 5) ^ 16'hA500;
      shadow[i] = DW'(i * 37 + 5) ^ 16'hA500;
    end
    ram[9'h1FF]    = 16'h1234;
    shadow[9'h1FF] = 16'h1234;

    // Reset held with every requester asking.
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b1; t_we[i] = 1'b1; t_addr[i] = AW'(9'h10 + i); t_wd[i] = DW'(16'hC000 + i);
    end
    apply();
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      chk("reset_outputs",
          64'({gnt, rvalid, rdata, mem_addr, mem_wdata, mem_rden, mem_wren, busy}), 64'(0));
    end
    reset = 1'b0;
    @(posedge clock); #1;
    chk("gnt_after_reset", 64'(gnt), 64'(3'b001));

    // All three held high: fixed priority keeps the loader, round-robin rotates.
    repeat (18) drive_cycle(0, 1);
    act = '0;
    apply();
    repeat (4) drive_cycle(0, 0);

    // Data requester write then read back.
    set_txn(2, 1'b1, 9'h05A, 16'hBEEF);
    wait_done("dm_write_done", 20);
    set_txn(2, 1'b0, 9'h05A, 16'h0000);
    wait_done("dm_read_done", 20);

    // Data and fetch contending, each dropping after its grant.
    set_txn(1, 1'b0, 9'h05A, 16'h1111);
    set_txn(2, 1'b1, 9'h033, 16'h2222);
    wait_done("contention_done", 30);

    // Reset in the cycle after a fetch grant: the read must vanish.
    set_txn(1, 1'b0, 9'h003, 16'h0000);
    for (int n = 0; n < 20 && !gnt_last[1]; n++) drive_cycle(0, 0);
    chk("midread_gnt_seen", 64'(gnt_last[1]), 64'(1));
    act = '0;
    apply();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("busy_after_reset", 64'(busy), 64'(0));
    repeat (RD_LAT + 4) drive_cycle(0, 0);

    // Long-latency read of a preloaded word.
    set_txn(2, 1'b0, 9'h1FF, 16'h0000);
    wait_done("lat_read_done", 20);

    // Random traffic.
    repeat (3000) drive_cycle(1, 0);
    act = '0;
    apply();
    repeat (4 * (RD_LAT + 3)) drive_cycle(0, 0);

    chk("gnt_queue_empty", 64'(gq.size()), 64'(0));
    chk("rvalid_queue_empty", 64'(rq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
